// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
//   Instruction-fetch stage feeding the IF/ID register. Owns the PC, fetches
//   from instruction memory under a req/ready handshake, parks a returned word
//   while IF/ID is stalled, and drops in-flight fetches overtaken by a
//   redirect (jr > jump > br_taken).
//
// Ports
//   clk, rst           clock; synchronous active-low reset
//   stall              IF/ID not written this cycle
//   br_taken/br_target branch redirect from ID
//   jump/jump_target   j/jal redirect from ID
//   jr/jr_target       jr redirect from ID
//   imem_req/addr      fetch request; addr held until imem_ready
//   imem_ready/rdata   request completes / instruction word
//   if_instr/if_pc4    instruction and its PC+4 (zero when !if_valid)
//   if_valid           if_instr is real this cycle
//   if_flush           squash IF/ID contents this cycle
// ---------------------------------------------------------------------------
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc4,
    output logic        if_valid,
    output logic        if_flush
);

    localparam logic [1:0] S_REQ     = 2'd0;
    localparam logic [1:0] S_HOLD    = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc4_q, hold_pc4_d;

    logic        redir;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    assign redir    = jr | jump | br_taken;
    assign target   = jr ? jr_target : (jump ? jump_target : br_target);
    assign pc_plus4 = pc_q + 32'd4;   // wraps modulo 2^32

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redir_pc_d   = redir_pc_q;
        hold_instr_d = hold_instr_q;
        hold_pc4_d   = hold_pc4_q;
        case (state_q)
            S_REQ: begin
                if (imem_ready) begin
                    if (redir) begin
                        pc_d = target;           // returned word is dropped
                    end else begin
                        pc_d = pc_plus4;
                        if (stall) begin
                            hold_instr_d = imem_rdata;
                            hold_pc4_d   = pc_plus4;
                            state_d      = S_HOLD;
                        end
                    end
                end else if (redir) begin
                    // Request cannot be aborted: remember target, eat the reply.
                    redir_pc_d = target;
                    state_d    = S_DISCARD;
                end
            end
            S_HOLD: begin
                if (redir) begin
                    pc_d    = target;
                    state_d = S_REQ;
                end else if (!stall) begin
                    state_d = S_REQ;             // held word consumed now
                end
            end
            S_DISCARD: begin
                if (redir) redir_pc_d = target;  // latest redirect wins
                if (imem_ready) begin
                    pc_d    = redir ? target : redir_pc_q;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            redir_pc_q   <= 32'h0;
            hold_instr_q <= 32'h0;
            hold_pc4_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redir_pc_q   <= redir_pc_d;
            hold_instr_q <= hold_instr_d;
            hold_pc4_q   <= hold_pc4_d;
        end
    end

    // Output logic; everything visible to neighbours is gated off in reset.
    logic        valid_raw;
    logic [31:0] instr_raw;
    logic [31:0] pc4_raw;

    always_comb begin
        valid_raw = 1'b0;
        instr_raw = imem_rdata;
        pc4_raw   = pc_plus4;
        case (state_q)
            S_REQ: valid_raw = imem_ready & ~redir & ~stall;
            S_HOLD: begin
                valid_raw = ~stall & ~redir;
                instr_raw = hold_instr_q;
                pc4_raw   = hold_pc4_q;
            end
            default: valid_raw = 1'b0;
        endcase
    end

    assign imem_req  = rst & (state_q != S_HOLD);
    assign imem_addr = pc_q;
    assign if_valid  = rst & valid_raw;
    assign if_instr  = if_valid ? instr_raw : 32'h0;
    assign if_pc4    = if_valid ? pc4_raw : 32'h0;
    assign if_flush  = rst & redir;

endmodule
